tdc_echo_sched: RTL and testbench

- Round-robin scheduler that shares one rise/fall pre-processing stage (pulse-width / distance-prep datapath) between NCH TDC stop channels.
- Each channel delivers rise/fall timestamp pairs as one-cycle strobes into a 1-deep holding register.
- The scheduler grants one channel at a time, presents its pair with a one-cycle new-sample pulse, and waits for the stage's completion pulse (or a timeout) before the next grant.
- Sits between the AS6500 TDC readout and the distance-calc preprocessing stage.

---
 rtl/tdc_echo_sched_pkg.sv | 18 +
 rtl/rr_arbiter_nch.sv | 29 ++
 rtl/tdc_echo_sched.sv | 167 ++++++++++++++++
 tb/tb_tdc_echo_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_echo_sched_pkg.sv
// Shared types and constants for the TDC echo scheduler.
package tdc_echo_sched_pkg;

    // One-hot scheduler states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } sched_state_t;

    // Default timestamp width of the AS6500 readout
    localparam int DW_DEFAULT = 16;

    // Overrun drop counter width and its saturation value
    localparam int                DROP_W   = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter_nch.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, with wrap.
module rr_arbiter_nch #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last_grant,
    output logic                   grant_valid,
    output logic [$clog2(NCH)-1:0] grant_idx
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester after last_grant wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = NCH; off >= 1; off--) begin
            cand = IW'((int'(last_grant) + off) % NCH);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tdc_echo_sched.sv
// Round-robin scheduler sharing one rise/fall pre-processing stage between NCH TDC stop channels.
module tdc_echo_sched
    import tdc_echo_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic                   i_clk_50m,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic [NCH-1:0]         i_ch_valid,
    input  logic [NCH*DW-1:0]      i_ch_rise,
    input  logic [NCH*DW-1:0]      i_ch_fall,
    input  logic                   i_dist_cal_sig,
    output logic                   o_tdc_new_sig,
    output logic [DW-1:0]          o_rise_data,
    output logic [DW-1:0]          o_fall_data,
    output logic [$clog2(NCH)-1:0] o_ch_id,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    output logic [DROP_W-1:0]      o_drop_cnt
);

    localparam int         IW       = $clog2(NCH);
    localparam int         CW       = $clog2(NCH + 1);
    localparam int         DSW      = DROP_W + 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    sched_state_t   state;
    sched_state_t   next_state;
    logic [7:0]     tmo_cnt;
    logic [7:0]     tmo_next;
    logic [NCH-1:0] hold_vld;
    logic [DW-1:0]  hold_rise [NCH];
    logic [DW-1:0]  hold_fall [NCH];
    logic [IW-1:0]  last_grant;
    logic           grant_valid;
    logic [IW-1:0]  grant_idx;
    logic           grant_fire;
    logic           err_now;
    logic [NCH-1:0] clear_vec;
    logic [NCH-1:0] drop_vec;
    logic [CW-1:0]  drop_num;
    logic [DSW-1:0] drop_sum;

    rr_arbiter_nch #(
        .NCH(NCH)
    ) u_arb (
        .req        (hold_vld),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign o_busy = (state != ST_IDLE);

    // Next-state logic: grant from IDLE, one ISSUE cycle, then WAIT for completion or timeout
    always_comb begin
        next_state = state;
        tmo_next   = tmo_cnt;
        grant_fire = 1'b0;
        err_now    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_enable && grant_valid) begin
                    grant_fire = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_next   = '0;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_dist_cal_sig) begin
                    next_state = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_now    = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    tmo_next = tmo_cnt + 8'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register and WAIT timeout counter
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= next_state;
            tmo_cnt <= tmo_next;
        end
    end

    // A granted channel is cleared this cycle; a strobe onto a still-held, uncleared channel is dropped
    always_comb begin
        clear_vec = '0;
        if (grant_fire) begin
            clear_vec[grant_idx] = 1'b1;
        end
        drop_vec = i_ch_valid & hold_vld & ~clear_vec;
        drop_num = '0;
        for (int k = 0; k < NCH; k++) begin
            drop_num = drop_num + CW'(drop_vec[k]);
        end
        drop_sum = {1'b0, o_drop_cnt} + DSW'(drop_num);
    end

    // Per-channel 1-deep holding registers
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            hold_vld <= '0;
            for (int k = 0; k < NCH; k++) begin
                hold_rise[k] <= '0;
                hold_fall[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (i_ch_valid[k] && !drop_vec[k]) begin
                    hold_vld[k]  <= 1'b1;
                    hold_rise[k] <= i_ch_rise[k*DW +: DW];
                    hold_fall[k] <= i_ch_fall[k*DW +: DW];
                end else if (clear_vec[k]) begin
                    hold_vld[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating overrun counter
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (drop_sum > {1'b0, DROP_MAX}) begin
            o_drop_cnt <= DROP_MAX;
        end else begin
            o_drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

    // Registered pulses and granted data, held stable until the next grant
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            o_tdc_new_sig <= 1'b0;
            o_timeout_err <= 1'b0;
            o_rise_data   <= '0;
            o_fall_data   <= '0;
            o_ch_id       <= '0;
            last_grant    <= '0;
        end else begin
            o_tdc_new_sig <= (state == ST_ISSUE);
            o_timeout_err <= err_now;
            if (grant_fire) begin
                o_rise_data <= hold_rise[grant_idx];
                o_fall_data <= hold_fall[grant_idx];
                o_ch_id     <= grant_idx;
                last_grant  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_tdc_echo_sched.sv
// Self-checking bench for tdc_echo_sched: directed scenarios followed by a randomized phase
// checked against a transaction-level model of pending pairs, grants and drops.
module tb_tdc_echo_sched;

    localparam int NCH     = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic              i_clk_50m;
    logic              i_rst;
    logic              i_enable;
    logic [NCH-1:0]    i_ch_valid;
    logic [NCH*DW-1:0] i_ch_rise;
    logic [NCH*DW-1:0] i_ch_fall;
    logic              i_dist_cal_sig;
    logic              o_tdc_new_sig;
    logic [DW-1:0]     o_rise_data;
    logic [DW-1:0]     o_fall_data;
    logic [1:0]        o_ch_id;
    logic              o_busy;
    logic              o_timeout_err;
    logic [15:0]       o_drop_cnt;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    tdc_echo_sched #(
        .NCH    (NCH),
        .DW     (DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk_50m     (i_clk_50m),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_ch_valid    (i_ch_valid),
        .i_ch_rise     (i_ch_rise),
        .i_ch_fall     (i_ch_fall),
        .i_dist_cal_sig(i_dist_cal_sig),
        .o_tdc_new_sig (o_tdc_new_sig),
        .o_rise_data   (o_rise_data),
        .o_fall_data   (o_fall_data),
        .o_ch_id       (o_ch_id),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err),
        .o_drop_cnt    (o_drop_cnt)
    );

    // 50 MHz clock
    initial i_clk_50m = 1'b0;
    always #10 i_clk_50m = ~i_clk_50m;

    // Hard stop in case something stalls the main sequence
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=stalled expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge i_clk_50m);
        edge_n++;
        @(negedge i_clk_50m);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pair on channel ch for a single cycle
    task automatic applyStimulus(input int ch, input logic [15:0] r, input logic [15:0] f);
        i_ch_valid          = '0;
        i_ch_valid[ch]      = 1'b1;
        i_ch_rise[ch*DW +: DW] = r;
        i_ch_fall[ch*DW +: DW] = f;
        tick();
        i_ch_valid = '0;
    endtask

    task automatic waitNewSig(input string tag, input int budget);
        int n = 0;
        while (o_tdc_new_sig !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, o_tdc_new_sig, 1'b1);
    endtask

    task automatic pulseDone();
        i_dist_cal_sig = 1'b1;
        tick();
        i_dist_cal_sig = 1'b0;
    endtask

    task automatic doReset();
        i_rst          = 1'b1;
        i_enable       = 1'b0;
        i_ch_valid     = '0;
        i_dist_cal_sig = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Randomized-phase model: pending pair per channel, last grant, drop total, earliest next grant
    bit   [NCH-1:0] m_vld;
    logic [15:0]    m_rise [NCH];
    logic [15:0]    m_fall [NCH];
    int             m_last;
    int             m_drops;
    int             next_free;
    int             done_edge;
    logic [NCH-1:0] cur_valid, prev_valid;
    logic [15:0]    cur_r [NCH];
    logic [15:0]    cur_f [NCH];
    logic [15:0]    prev_r [NCH];
    logic [15:0]    prev_f [NCH];
    logic           cur_en, prev_en;
    logic [15:0]    prev_drop_obs;

    initial begin
        int n;
        int new_cnt;
        int err_cnt;
        int busy_cnt;
        int order [4];
        bit exp_grant;
        int exp_ch;
        int exp_drop;

        i_ch_rise = '0;
        i_ch_fall = '0;
        doReset();

        // Reset state
        checkOutput("reset_new_sig", o_tdc_new_sig, 1'b0);
        checkOutput("reset_busy", o_busy, 1'b0);
        checkOutput("reset_err", o_timeout_err, 1'b0);
        checkOutput("reset_drop", o_drop_cnt, 16'h0);
        checkOutput("reset_ch_id", o_ch_id, 2'd0);
        checkOutput("reset_rise", o_rise_data, 16'h0);

        // Single pair: new_sig appears exactly three cycles after the strobe
        $display("[TB] single pair");
        i_enable = 1'b1;
        applyStimulus(1, 16'h0100, 16'h0180);
        checkOutput("single_t1_new_sig", o_tdc_new_sig, 1'b0);
        tick();
        checkOutput("single_t2_new_sig", o_tdc_new_sig, 1'b0);
        tick();
        checkOutput("single_t3_new_sig", o_tdc_new_sig, 1'b1);
        checkOutput("single_rise", o_rise_data, 16'h0100);
        checkOutput("single_fall", o_fall_data, 16'h0180);
        checkOutput("single_ch", o_ch_id, 2'd1);
        tick();
        checkOutput("single_pulse_width", o_tdc_new_sig, 1'b0);
        tick();
        tick();
        checkOutput("single_busy_wait", o_busy, 1'b1);
        checkOutput("single_rise_stable", o_rise_data, 16'h0100);
        pulseDone();
        checkOutput("single_busy_done", o_busy, 1'b0);

        // Round-robin: all channels at once from last_grant 0 -> 1,2,3,0
        $display("[TB] round robin");
        doReset();
        i_enable   = 1'b1;
        i_ch_valid = '1;
        for (int k = 0; k < NCH; k++) begin
            i_ch_rise[k*DW +: DW] = 16'h1000 + 16'(k);
            i_ch_fall[k*DW +: DW] = 16'h2000 + 16'(k);
        end
        tick();
        i_ch_valid = '0;
        order = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            waitNewSig("rr_new_sig", 10);
            checkOutput("rr_ch", o_ch_id, 32'(order[i]));
            checkOutput("rr_rise", o_rise_data, 32'(16'h1000 + 16'(order[i])));
            checkOutput("rr_fall", o_fall_data, 32'(16'h2000 + 16'(order[i])));
            pulseDone();
        end
        checkOutput("rr_drop", o_drop_cnt, 16'h0);

        // Overrun while disabled: the first pair survives, the second is counted as a drop
        $display("[TB] overrun");
        doReset();
        i_enable = 1'b0;
        applyStimulus(2, 16'h0010, 16'h0020);
        applyStimulus(2, 16'h0030, 16'h0040);
        checkOutput("ovr_drop", o_drop_cnt, 16'h1);
        checkOutput("ovr_no_grant", o_busy, 1'b0);
        i_enable = 1'b1;
        waitNewSig("ovr_new_sig", 10);
        checkOutput("ovr_ch", o_ch_id, 2'd2);
        checkOutput("ovr_rise", o_rise_data, 16'h0010);
        checkOutput("ovr_fall", o_fall_data, 16'h0020);
        pulseDone();

        // Timeout: ch3 granted first, never completes; ch0 follows after the error
        $display("[TB] timeout");
        doReset();
        i_enable   = 1'b1;
        i_ch_valid = 4'b1001;
        i_ch_rise[0 +: DW]    = 16'hA000;
        i_ch_fall[0 +: DW]    = 16'hA001;
        i_ch_rise[3*DW +: DW] = 16'hB000;
        i_ch_fall[3*DW +: DW] = 16'hB001;
        tick();
        i_ch_valid = '0;
        waitNewSig("tmo_new_sig", 10);
        checkOutput("tmo_first_ch", o_ch_id, 2'd3);
        n = 0;
        while (o_timeout_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("tmo_latency", n, TIMEOUT);
        checkOutput("tmo_busy_after", o_busy, 1'b0);
        checkOutput("tmo_rise_kept", o_rise_data, 16'hB000);
        tick();
        checkOutput("tmo_err_width", o_timeout_err, 1'b0);
        waitNewSig("tmo_next_new_sig", 10);
        checkOutput("tmo_next_ch", o_ch_id, 2'd0);
        checkOutput("tmo_next_rise", o_rise_data, 16'hA000);
        pulseDone();

        // Reset in WAIT: everything clears, ch2's held pair is lost, late done is ignored
        $display("[TB] reset mid-wait");
        doReset();
        i_enable   = 1'b1;
        i_ch_valid = 4'b0110;
        tick();
        i_ch_valid = '0;
        waitNewSig("rst_new_sig", 10);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("rst_busy", o_busy, 1'b0);
        checkOutput("rst_new_sig_low", o_tdc_new_sig, 1'b0);
        checkOutput("rst_err_low", o_timeout_err, 1'b0);
        checkOutput("rst_ch", o_ch_id, 2'd0);
        checkOutput("rst_rise", o_rise_data, 16'h0);
        checkOutput("rst_fall", o_fall_data, 16'h0);
        new_cnt = 0;
        err_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            i_dist_cal_sig = (i == 3);
            tick();
            new_cnt  += int'(o_tdc_new_sig);
            err_cnt  += int'(o_timeout_err);
            busy_cnt += int'(o_busy);
        end
        i_dist_cal_sig = 1'b0;
        checkOutput("rst_no_new_sig", new_cnt, 0);
        checkOutput("rst_no_err", err_cnt, 0);
        checkOutput("rst_no_busy", busy_cnt, 0);

        // Drop saturation: every channel strobes every cycle while disabled (4 drops per cycle)
        $display("[TB] drop saturation");
        doReset();
        i_enable   = 1'b0;
        i_ch_valid = '1;
        for (int i = 1; i <= 17600; i++) begin
            tick();
            if (i == 1000) checkOutput("sat_partial", o_drop_cnt, 16'(4 * 999));
        end
        i_ch_valid = '0;
        tick();
        checkOutput("sat_full", o_drop_cnt, 16'hFFFF);

        // Randomized traffic against the transaction model
        $display("[TB] random traffic");
        doReset();
        m_vld         = '0;
        m_last        = 0;
        m_drops       = 0;
        next_free     = 0;
        done_edge     = -10;
        prev_valid    = '0;
        prev_en       = 1'b0;
        cur_valid     = '0;
        cur_en        = 1'b0;
        prev_drop_obs = 16'h0;
        for (int k = 0; k < NCH; k++) begin
            prev_r[k] = '0;
            prev_f[k] = '0;
            cur_r[k]  = '0;
            cur_f[k]  = '0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            // A grant decided at edge_n-1 shows up as new_sig now
            exp_grant = 1'b0;
            exp_ch    = 0;
            for (int off = 1; off <= NCH; off++) begin
                if (!exp_grant && m_vld[(m_last + off) % NCH]) begin
                    exp_grant = 1'b1;
                    exp_ch    = (m_last + off) % NCH;
                end
            end
            exp_grant = exp_grant && prev_en && (edge_n - 1 >= next_free);
            checkOutput("rnd_new_sig", o_tdc_new_sig, exp_grant);
            if (exp_grant) begin
                checkOutput("rnd_ch", o_ch_id, 32'(exp_ch));
                checkOutput("rnd_rise", o_rise_data, m_rise[exp_ch]);
                checkOutput("rnd_fall", o_fall_data, m_fall[exp_ch]);
                m_vld[exp_ch] = 1'b0;
                m_last        = exp_ch;
                done_edge     = edge_n + 1 + int'($urandom_range(0, 3));
                next_free     = done_edge + 1;
            end
            // Strobes sampled at edge_n-1: load into an empty slot, otherwise drop
            for (int k = 0; k < NCH; k++) begin
                if (prev_valid[k]) begin
                    if (m_vld[k]) begin
                        m_drops++;
                    end else begin
                        m_vld[k]  = 1'b1;
                        m_rise[k] = prev_r[k];
                        m_fall[k] = prev_f[k];
                    end
                end
            end
            exp_drop = (m_drops > 65535) ? 65535 : m_drops;
            checkOutput("rnd_drop", prev_drop_obs, exp_drop);
            checkOutput("rnd_no_err", o_timeout_err, 1'b0);

            prev_valid = cur_valid;
            prev_en    = cur_en;
            for (int k = 0; k < NCH; k++) begin
                prev_r[k] = cur_r[k];
                prev_f[k] = cur_f[k];
            end
            for (int k = 0; k < NCH; k++) begin
                cur_valid[k] = (cyc < 440) && ($urandom_range(0, 3) == 0);
                cur_r[k]     = 16'($urandom);
                cur_f[k]     = 16'($urandom);
                i_ch_rise[k*DW +: DW] = cur_r[k];
                i_ch_fall[k*DW +: DW] = cur_f[k];
            end
            cur_en         = (cyc >= 440) || ($urandom_range(0, 3) != 0);
            i_ch_valid     = cur_valid;
            i_enable       = cur_en;
            i_dist_cal_sig = (edge_n + 1 == done_edge);
            prev_drop_obs  = o_drop_cnt;
            tick();
        end
        i_ch_valid     = '0;
        i_dist_cal_sig = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
